// File: rtl/mem_pkg.sv
// Shared types and defaults for the instruction-memory boot loader.
// Holds the loader FSM state encoding and the default frame start byte.
package mem_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LEN_LO = 3'd1,
    LEN_HI = 3'd2,
    DATA   = 3'd3,
    CHK    = 3'd4,
    DONE   = 3'd5,
    ERROR  = 3'd6
  } loader_state_e;

  localparam logic [7:0] LoaderMagic = 8'hA5;

endpackage

// File: rtl/loader_word_assembler.sv
// Collects payload bytes into little-endian 32-bit words and keeps the running
// 8-bit wrap-around checksum of every byte it has seen since the last clear.
module loader_word_assembler (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        clear,
  input  logic        byte_in,
  input  logic [7:0]  data,
  output logic        word_valid,
  output logic [31:0] word,
  output logic [7:0]  checksum
);

  logic [1:0]  lane;
  logic [23:0] low_bytes;
  logic [7:0]  sum;

  // The top lane is never stored: the word is completed combinationally from
  // the incoming byte, so the write can be registered on that same transfer.
  assign word_valid = byte_in && (lane == 2'd3);
  assign word       = {data, low_bytes};
  assign checksum   = sum;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values of its neighbours, independent of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lane      <= 2'd0;
      low_bytes <= 24'd0;
      sum       <= 8'd0;
    end else if (clear) begin
      lane      <= 2'd0;
      low_bytes <= 24'd0;
      sum       <= 8'd0;
    end else if (byte_in) begin
      sum  <= sum + data;
      lane <= lane + 2'd1;
      case (lane)
        2'd0:    low_bytes[7:0]   <= data;
        2'd1:    low_bytes[15:8]  <= data;
        2'd2:    low_bytes[23:16] <= data;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Boot-time loader: parses framed bytes, writes words to instruction memory from
// address 0 and releases the CPU only after a frame arrives with a good checksum.
module imem_loader
  import mem_pkg::*;
#(
  parameter int         MemSize       = 'h0000_1000,
  parameter logic [7:0] Magic         = LoaderMagic,
  parameter int         TimeoutCycles = 1_000_000,
  localparam int        MemAddrWidth  = $clog2(MemSize)
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [7:0]              rx_data,
  input  logic                    rx_valid,
  output logic                    rx_ready,
  output logic                    we,
  output logic [MemAddrWidth-1:0] waddr,
  output logic [31:0]             wdata,
  output logic                    cpu_hold,
  output logic                    done,
  output logic                    error
);

  localparam int                  TcWidth  = $clog2(TimeoutCycles + 1);
  localparam logic [TcWidth-1:0]  TcLast   = TcWidth'(TimeoutCycles - 1);
  localparam logic [TcWidth-1:0]  TcMax    = TcWidth'(TimeoutCycles);
  localparam logic [16:0]         MaxWords = 17'(MemSize / 4);

  loader_state_e      state;
  logic [7:0]         len_lo;
  logic [15:0]        n_words;
  logic [15:0]        idx;
  logic [TcWidth-1:0] tcnt;

  logic        transfer;
  logic        active;
  logic        timeout;
  logic [15:0] len_in;
  logic        len_bad;
  logic        asm_clear;
  logic        asm_byte;
  logic        word_valid;
  logic [31:0] word;
  logic [7:0]  checksum;
  logic [7:0]  chk_sum;
  logic        chk_ok;

  assign transfer  = rx_valid && rx_ready;
  assign active    = (state == LEN_LO) || (state == LEN_HI) ||
                     (state == DATA)   || (state == CHK);
  assign timeout   = active && !transfer && (tcnt == TcLast);
  assign len_in    = {rx_data, len_lo};
  assign len_bad   = (len_in == 16'd0) || ({1'b0, len_in} > MaxWords);
  assign asm_clear = transfer && (state == LEN_HI) && !len_bad;
  assign asm_byte  = transfer && (state == DATA);
  assign chk_sum   = checksum + rx_data;
  assign chk_ok    = (chk_sum == 8'd0);

  loader_word_assembler u_asm (
    .clk        (clk),
    .reset_n    (reset_n),
    .clear      (asm_clear),
    .byte_in    (asm_byte),
    .data       (rx_data),
    .word_valid (word_valid),
    .word       (word),
    .checksum   (checksum)
  );

  // Idle-cycle counter; only meaningful inside a frame, saturates rather than wraps.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tcnt <= '0;
    end else if (transfer || !active) begin
      tcnt <= '0;
    end else if (tcnt != TcMax) begin
      tcnt <= tcnt + 1'b1;
    end
  end

  // NOTE: only the loader's own registers are reset here; the instruction memory
  // behind the write port is deliberately left untouched by reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      len_lo   <= 8'd0;
      n_words  <= 16'd0;
      idx      <= 16'd0;
      rx_ready <= 1'b0;
      we       <= 1'b0;
      waddr    <= '0;
      wdata    <= 32'd0;
      cpu_hold <= 1'b1;
      done     <= 1'b0;
      error    <= 1'b0;
    end else begin
      rx_ready <= 1'b1;
      we       <= 1'b0;
      case (state)
        IDLE: begin
          if (transfer && (rx_data == Magic)) state <= LEN_LO;
        end
        LEN_LO: begin
          if (transfer) begin
            len_lo <= rx_data;
            state  <= LEN_HI;
          end else if (timeout) begin
            state <= ERROR;
            error <= 1'b1;
          end
        end
        LEN_HI: begin
          if (transfer) begin
            if (len_bad) begin
              state <= ERROR;
              error <= 1'b1;
            end else begin
              n_words <= len_in;
              idx     <= 16'd0;
              state   <= DATA;
            end
          end else if (timeout) begin
            state <= ERROR;
            error <= 1'b1;
          end
        end
        DATA: begin
          if (word_valid) begin
            we    <= 1'b1;
            wdata <= word;
            waddr <= MemAddrWidth'({idx, 2'b00});
            if (idx == n_words - 16'd1) state <= CHK;
            else                        idx   <= idx + 16'd1;
          end else if (timeout) begin
            state <= ERROR;
            error <= 1'b1;
          end
        end
        CHK: begin
          if (transfer) begin
            if (chk_ok) begin
              state    <= DONE;
              done     <= 1'b1;
              cpu_hold <= 1'b0;
            end else begin
              state <= ERROR;
              error <= 1'b1;
            end
          end else if (timeout) begin
            state <= ERROR;
            error <= 1'b1;
          end
        end
        DONE: begin
          // A new frame re-arms the hold immediately: the old image is being replaced.
          if (transfer && (rx_data == Magic)) begin
            state    <= LEN_LO;
            done     <= 1'b0;
            cpu_hold <= 1'b1;
          end
        end
        ERROR: begin
          if (transfer && (rx_data == Magic)) begin
            state <= LEN_LO;
            error <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: directed frame table, multi-cycle corner
// sequences and randomized frames checked against a frame-level reference model.
module tb_imem_loader;

  localparam int         TimeoutCycles = 16;
  localparam logic [7:0] MagicByte     = 8'hA5;
  localparam int         MaxWords      = 1024;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [7:0]  rx_data = 8'd0;
  logic        rx_valid = 1'b0;
  logic        rx_ready;
  logic        we;
  logic [11:0] waddr;
  logic [31:0] wdata;
  logic        cpu_hold;
  logic        done;
  logic        error;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  typedef struct {
    string        name;
    int           nb;
    logic [127:0] bytes;
    logic         exp_done;
    logic         exp_err;
    int           exp_nw;
    logic [31:0]  w0;
    logic [31:0]  w1;
  } vec_t;

  wr_t        wr_q[$];
  wr_t        exp_q[$];
  logic [7:0] stim_q[$];
  logic       m_done;
  logic       m_err;
  vec_t       vecs[6];

  imem_loader #(.TimeoutCycles(TimeoutCycles)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .we       (we),
    .waddr    (waddr),
    .wdata    (wdata),
    .cpu_hold (cpu_hold),
    .done     (done),
    .error    (error)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (we) wr_q.push_back('{32'(waddr), wdata});
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] lalign(input logic [127:0] v, input int nb);
    return v << (8 * (16 - nb));
  endfunction

  task automatic check_reset_vals(input string tag);
    check({tag, "_rx_ready"}, 32'(rx_ready), 0);
    check({tag, "_we"},       32'(we),       0);
    check({tag, "_waddr"},    32'(waddr),    0);
    check({tag, "_wdata"},    wdata,         0);
    check({tag, "_flags"},    {29'd0, cpu_hold, done, error}, 32'b100);
  endtask

  task automatic do_reset(input bit check_vals);
    rx_valid = 1'b0;
    rx_data  = 8'd0;
    @(negedge clk);
    reset_n = 1'b0;
    #2;
    if (check_vals) check_reset_vals("reset");
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    if (check_vals) check("ready_after_release", 32'(rx_ready), 1);
    wr_q.delete();
  endtask

  task automatic send_byte(input logic [7:0] b);
    int waited = 0;
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    while (!rx_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (!rx_ready) check("rx_ready_wait", 32'(rx_ready), 1);
    @(posedge clk);
    #1 rx_valid = 1'b0;
  endtask

  // Frame-level reference: walks the byte stream by the framing rules alone.
  function automatic void model();
    int i = 0;
    while (i < stim_q.size()) begin
      if (stim_q[i] != MagicByte) begin
        i++;
        continue;
      end
      i++;
      m_done = 1'b0;
      m_err  = 1'b0;
      if (i + 2 > stim_q.size()) break;
      begin
        int n = {stim_q[i+1], stim_q[i]};
        int sum = 0;
        i += 2;
        if (n == 0 || n > MaxWords) begin
          m_err = 1'b1;
          continue;
        end
        for (int w = 0; w < n; w++) begin
          logic [31:0] word = 0;
          for (int k = 0; k < 4; k++) begin
            word = word | (32'(stim_q[i]) << (8 * k));
            sum += stim_q[i];
            i++;
          end
          exp_q.push_back('{32'(w * 4), word});
        end
        sum += stim_q[i];
        i++;
        if (sum % 256 == 0) m_done = 1'b1;
        else                m_err  = 1'b1;
      end
    end
  endfunction

  task automatic send_good_frame_a();
    logic [7:0] f[12] = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
                          8'h6F, 8'h00, 8'h00, 8'h00, 8'h7E};
    foreach (f[k]) send_byte(f[k]);
  endtask

  initial begin
    vecs[0] = '{"good", 12, lalign({8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
                8'h6F, 8'h00, 8'h00, 8'h00, 8'h7E}, 12), 1'b1, 1'b0, 2, 32'h13, 32'h6F};
    vecs[1] = '{"badchk", 12, lalign({8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
                8'h6F, 8'h00, 8'h00, 8'h00, 8'h7F}, 12), 1'b0, 1'b1, 2, 32'h13, 32'h6F};
    vecs[2] = '{"len0", 3, lalign({8'hA5, 8'h00, 8'h00}, 3), 1'b0, 1'b1, 0, 32'h0, 32'h0};
    vecs[3] = '{"len1025", 3, lalign({8'hA5, 8'h01, 8'h04}, 3), 1'b0, 1'b1, 0, 32'h0, 32'h0};
    vecs[4] = '{"junk", 15, lalign({8'h00, 8'hFF, 8'h13, 8'hA5, 8'h02, 8'h00, 8'h13,
                8'h00, 8'h00, 8'h00, 8'h6F, 8'h00, 8'h00, 8'h00, 8'h7E}, 15),
                1'b1, 1'b0, 2, 32'h13, 32'h6F};
    vecs[5] = '{"magicdata", 8, lalign({8'hA5, 8'h01, 8'h00, 8'hA5, 8'hA5, 8'hA5,
                8'hA5, 8'h6C}, 8), 1'b1, 1'b0, 1, 32'hA5A5A5A5, 32'h0};

    // Reset state is checked once, with reset held.
    do_reset(1'b1);

    for (int v = 0; v < 6; v++) begin
      do_reset(1'b0);
      for (int k = 0; k < vecs[v].nb; k++) send_byte(vecs[v].bytes[127-8*k -: 8]);
      check({vecs[v].name, "_done"},  32'(done),     32'(vecs[v].exp_done));
      check({vecs[v].name, "_error"}, 32'(error),    32'(vecs[v].exp_err));
      check({vecs[v].name, "_hold"},  32'(cpu_hold), 32'(!vecs[v].exp_done));
      repeat (2) @(negedge clk);
      check({vecs[v].name, "_nwrites"}, 32'(wr_q.size()), 32'(vecs[v].exp_nw));
      if (vecs[v].exp_nw >= 1 && wr_q.size() >= 1) begin
        check({vecs[v].name, "_w0_addr"}, wr_q[0].addr, 32'h0);
        check({vecs[v].name, "_w0_data"}, wr_q[0].data, vecs[v].w0);
      end
      if (vecs[v].exp_nw >= 2 && wr_q.size() >= 2) begin
        check({vecs[v].name, "_w1_addr"}, wr_q[1].addr, 32'h4);
        check({vecs[v].name, "_w1_data"}, wr_q[1].data, vecs[v].w1);
      end
    end

    // Stall mid-word: timeout after exactly TimeoutCycles idle cycles, no partial write.
    do_reset(1'b0);
    begin
      logic [7:0] f[6] = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00};
      int cyc = 0;
      foreach (f[k]) send_byte(f[k]);
      while (!error && cyc < 40) begin
        @(posedge clk);
        #1;
        cyc++;
      end
      check("stall_cycles", 32'(cyc), 32'(TimeoutCycles));
      check("stall_hold", 32'(cpu_hold), 1);
      repeat (2) @(negedge clk);
      check("stall_nwrites", 32'(wr_q.size()), 0);
    end

    // Asynchronous reset in the middle of DATA, then a clean download.
    do_reset(1'b0);
    begin
      logic [7:0] f[5] = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00};
      foreach (f[k]) send_byte(f[k]);
      #2 reset_n = 1'b0;
      #1 check_reset_vals("midreset");
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      wr_q.delete();
      send_good_frame_a();
      check("midreset_done", 32'(done), 1);
      repeat (2) @(negedge clk);
      check("midreset_nwrites", 32'(wr_q.size()), 2);
    end

    // Reload from DONE: hold reasserts on the magic byte, new word lands at 0.
    begin
      logic [7:0] f[8] = '{8'hA5, 8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h56};
      wr_q.delete();
      send_byte(f[0]);
      check("reload_hold", {30'd0, cpu_hold, done}, 32'b10);
      for (int k = 1; k < 8; k++) send_byte(f[k]);
      check("reload_done", {30'd0, cpu_hold, done}, 32'b01);
      repeat (2) @(negedge clk);
      check("reload_nwrites", 32'(wr_q.size()), 1);
      if (wr_q.size() >= 1) begin
        check("reload_addr", wr_q[0].addr, 32'h0);
        check("reload_data", wr_q[0].data, 32'h44332211);
      end
    end

    // Randomized frames back to back, no reset between them.
    do_reset(1'b0);
    m_done = 1'b0;
    m_err  = 1'b0;
    for (int f = 0; f < 40; f++) begin
      int kind  = $urandom_range(0, 9);
      int nw    = $urandom_range(1, 4);
      int sum   = 0;
      int nlen;
      stim_q.delete();
      exp_q.delete();
      wr_q.delete();
      repeat ($urandom_range(0, 2)) begin
        logic [7:0] j = 8'($urandom_range(0, 255));
        if (j == MagicByte) j = 8'h00;
        stim_q.push_back(j);
      end
      stim_q.push_back(MagicByte);
      nlen = (kind == 0) ? 0 : (kind == 1) ? MaxWords + $urandom_range(1, 100) : nw;
      stim_q.push_back(nlen[7:0]);
      stim_q.push_back(nlen[15:8]);
      if (kind > 1) begin
        for (int b = 0; b < 4 * nw; b++) begin
          logic [7:0] d = 8'($urandom_range(0, 255));
          sum += d;
          stim_q.push_back(d);
        end
        begin
          logic [7:0] chk = 8'(256 - (sum % 256));
          if ($urandom_range(0, 3) == 0) chk = chk + 8'($urandom_range(1, 255));
          stim_q.push_back(chk);
        end
      end
      model();
      foreach (stim_q[k]) begin
        repeat ($urandom_range(0, 3)) @(posedge clk);
        send_byte(stim_q[k]);
      end
      repeat (3) @(negedge clk);
      check($sformatf("rand%0d_done", f),  32'(done),     32'(m_done));
      check($sformatf("rand%0d_error", f), 32'(error),    32'(m_err));
      check($sformatf("rand%0d_hold", f),  32'(cpu_hold), 32'(!m_done));
      check($sformatf("rand%0d_nwrites", f), 32'(wr_q.size()), 32'(exp_q.size()));
      for (int k = 0; k < exp_q.size() && k < wr_q.size(); k++) begin
        check($sformatf("rand%0d_addr%0d", f, k), wr_q[k].addr, exp_q[k].addr);
        check($sformatf("rand%0d_data%0d", f, k), wr_q[k].data, exp_q[k].data);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "simulation time limit");
  end

endmodule
